fifo_to_axi4_stream: RTL and testbench

- Read-side adapter that drains a single-clock FIFO and drives an AXI4-Stream master.
- The FIFO has a standard read port: read request, 1-cycle read latency, empty flag.
- The FIFO word is the packed AXI4-Stream word {tdata, tstrb, tkeep, tlast, tuser, tdest, tid}.
- Sits between a packet FIFO's memory and downstream stream consumers. Provides full throughput (1 word/clk) with fully registered pkt_o outputs.

---
 rtl/axi4_stream_fifo_pkg.sv | 10 +
 rtl/axi4_stream_if.sv | 27 ++
 rtl/sc_skid_buf_2.sv | 59 +++++
 rtl/fifo_to_axi4_stream.sv | 96 +++++++++
 tb/tb_fifo_to_axi4_stream.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_stream_fifo_pkg.sv
// Shared definitions for FIFOs that store packed AXI4-Stream words.
// Packed word field order, MSB to LSB: tdata, tstrb, tkeep, tlast, tuser, tdest, tid.
package axi4_stream_fifo_pkg;

    function automatic int fifo_word_width(input int data_w, input int user_w,
                                           input int dest_w, input int id_w);
        return data_w + 2 * (data_w / 8) + 1 + user_w + dest_w + id_w;
    endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle with master and slave views.
interface axi4_stream_if #(
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 1,
    parameter int DEST_WIDTH = 1,
    parameter int ID_WIDTH   = 1
);
    logic                    tvalid;
    logic                    tready;
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tlast;
    logic [USER_WIDTH-1:0]   tuser;
    logic [DEST_WIDTH-1:0]   tdest;
    logic [ID_WIDTH-1:0]     tid;

    modport master (
        output tvalid, tdata, tstrb, tkeep, tlast, tuser, tdest, tid,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tstrb, tkeep, tlast, tuser, tdest, tid,
        output tready
    );
endinterface

// File: rtl/sc_skid_buf_2.sv
// Generic two-entry FIFO-ordered buffer; the head entry is always the registered output.
module sc_skid_buf_2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic [1:0]       cnt_o
);
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [1:0]       r_cnt;
    logic             w_rd;

    assign w_rd = rd_i && (r_cnt != 2'd0);

    // A write while full is refused; the reader's credit check keeps that from happening.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= 2'd0;
        end else begin
            case ({wr_i, w_rd})
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_head <= wr_data_i;
                        r_cnt  <= 2'd1;
                    end else if (r_cnt == 2'd1) begin
                        r_tail <= wr_data_i;
                        r_cnt  <= 2'd2;
                    end
                end
                2'b01: begin
                    if (r_cnt == 2'd2) begin
                        r_head <= r_tail;
                    end
                    r_cnt <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd2) begin
                        r_head <= r_tail;
                        r_tail <= wr_data_i;
                    end else begin
                        r_head <= wr_data_i;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rd_data_o = r_head;
    assign cnt_o     = r_cnt;
endmodule

// File: rtl/fifo_to_axi4_stream.sv
// Drains a 1-cycle-latency FIFO into an AXI4-Stream master through a 2-entry buffer.
// Define FIFO_TO_AXI4_STREAM_STAT_EN to enable the word/packet counters.
module fifo_to_axi4_stream
    import axi4_stream_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 1,
    parameter int DEST_WIDTH = 1,
    parameter int ID_WIDTH   = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        fifo_rd_o,
    input  logic [fifo_word_width(DATA_WIDTH, USER_WIDTH, DEST_WIDTH, ID_WIDTH)-1:0] fifo_rd_data_i,
    input  logic        fifo_empty_i,
    axi4_stream_if.master pkt_o,
    output logic [31:0] pkt_cnt_o,
    output logic [31:0] word_cnt_o
);
    localparam int KEEP_WIDTH = DATA_WIDTH / 8;
    localparam int FIFO_WIDTH = fifo_word_width(DATA_WIDTH, USER_WIDTH, DEST_WIDTH, ID_WIDTH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] tdata;
        logic [KEEP_WIDTH-1:0] tstrb;
        logic [KEEP_WIDTH-1:0] tkeep;
        logic                  tlast;
        logic [USER_WIDTH-1:0] tuser;
        logic [DEST_WIDTH-1:0] tdest;
        logic [ID_WIDTH-1:0]   tid;
    } word_t;

    word_t      w_head;
    logic [1:0] w_buf_cnt;
    logic [1:0] w_occ;
    logic       w_pop;
    logic       r_rd_pend;

    assign w_pop = pkt_o.tvalid && pkt_o.tready;

    // Slots committed after this cycle; buffer plus in-flight read never exceeds two.
    assign w_occ     = w_buf_cnt + {1'b0, r_rd_pend} - {1'b0, w_pop};
    assign fifo_rd_o = !rst_i && !fifo_empty_i && (w_occ < 2'd2);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_pend <= 1'b0;
        end else begin
            r_rd_pend <= fifo_rd_o;
        end
    end

    sc_skid_buf_2 #(
        .WIDTH (FIFO_WIDTH)
    ) u_buf (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_i      (r_rd_pend),
        .wr_data_i (fifo_rd_data_i),
        .rd_i      (w_pop),
        .rd_data_o (w_head),
        .cnt_o     (w_buf_cnt)
    );

    assign pkt_o.tvalid = (w_buf_cnt != 2'd0);
    assign pkt_o.tdata  = w_head.tdata;
    assign pkt_o.tstrb  = w_head.tstrb;
    assign pkt_o.tkeep  = w_head.tkeep;
    assign pkt_o.tlast  = w_head.tlast;
    assign pkt_o.tuser  = w_head.tuser;
    assign pkt_o.tdest  = w_head.tdest;
    assign pkt_o.tid    = w_head.tid;

`ifdef FIFO_TO_AXI4_STREAM_STAT_EN
    logic [31:0] r_word_cnt;
    logic [31:0] r_pkt_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_word_cnt <= 32'd0;
            r_pkt_cnt  <= 32'd0;
        end else if (w_pop) begin
            r_word_cnt <= r_word_cnt + 32'd1;
            if (w_head.tlast) begin
                r_pkt_cnt <= r_pkt_cnt + 32'd1;
            end
        end
    end

    assign word_cnt_o = r_word_cnt;
    assign pkt_cnt_o  = r_pkt_cnt;
`else
    assign word_cnt_o = 32'd0;
    assign pkt_cnt_o  = 32'd0;
`endif
endmodule

// File: tb/tb_fifo_to_axi4_stream.sv
// Directed bench for fifo_to_axi4_stream with a behavioural 1-cycle-latency FIFO model.
module tb_fifo_to_axi4_stream;
    localparam int FW = 44;
    localparam logic [FW-1:0] GARBAGE = 44'hBAD_DEAD_BEEF;

    logic          clk;
    logic          rst;
    logic          fifoRd;
    logic [FW-1:0] fifoData;
    logic          fifoEmpty;
    logic [31:0]   pktCnt;
    logic [31:0]   wordCnt;

    axi4_stream_if #(.DATA_WIDTH(32), .USER_WIDTH(1), .DEST_WIDTH(1), .ID_WIDTH(1)) pkt ();

    fifo_to_axi4_stream #(
        .DATA_WIDTH (32),
        .USER_WIDTH (1),
        .DEST_WIDTH (1),
        .ID_WIDTH   (1)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .fifo_rd_o      (fifoRd),
        .fifo_rd_data_i (fifoData),
        .fifo_empty_i   (fifoEmpty),
        .pkt_o          (pkt),
        .pkt_cnt_o      (pktCnt),
        .word_cnt_o     (wordCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [FW-1:0] q[$];
    logic [FW-1:0] expWords[$];
    logic [FW-1:0] outWords[$];
    int outstanding = 0;
    int rdEmptyViol = 0;
    int overViol = 0;
    int holdViol = 0;

    logic          sRst, sRd, sValid, sPop;
    logic [FW-1:0] sWord;
    logic          prevValid = 1'b0;
    logic          prevPop = 1'b0;
    logic [FW-1:0] prevWord = '0;

    function automatic logic [FW-1:0] mk(input logic [31:0] d, input logic last);
        return {d, 4'hF, 4'hF, last, d[0], d[1], d[2]};
    endfunction

    task automatic push(input logic [FW-1:0] w);
        q.push_back(w);
        expWords.push_back(w);
        fifoEmpty = 1'b0;
    endtask

    // One clock: sample at the falling edge, then play the FIFO's registered read port.
    task automatic step();
        @(negedge clk);
        sRst   = rst;
        sRd    = fifoRd;
        sValid = pkt.tvalid;
        sPop   = pkt.tvalid && pkt.tready;
        sWord  = {pkt.tdata, pkt.tstrb, pkt.tkeep, pkt.tlast, pkt.tuser, pkt.tdest, pkt.tid};
        if (!sRst) begin
            if (sRd && fifoEmpty) rdEmptyViol++;
            if (prevValid && !prevPop && (!sValid || sWord !== prevWord)) holdViol++;
            if (sPop) outWords.push_back(sWord);
            outstanding += int'(sRd) - int'(sPop);
            if (outstanding > 2) overViol++;
        end
        prevValid = sValid && !sRst;
        prevPop   = sPop;
        prevWord  = sWord;
        @(posedge clk);
        #1;
        if (sRst) begin
            q.delete();
            outstanding = 0;
            fifoEmpty   = 1'b1;
            fifoData    = GARBAGE;
            prevValid   = 1'b0;
        end else begin
            if (sRd && q.size() > 0) fifoData = q.pop_front();
            else fifoData = GARBAGE;
            fifoEmpty = (q.size() == 0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pkt.tready = 1'b0;
        step();
        step();
        expWords.delete();
        outWords.delete();
        rdEmptyViol = 0;
        overViol = 0;
        holdViol = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (sValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_tvalid got=%b want=0", sValid); end
        checks++; if (sRd !== 1'b0) begin failures++; $display("[TB] FAIL reset_fifo_rd got=%b want=0", sRd); end
        checks++; if (sWord !== '0) begin failures++; $display("[TB] FAIL reset_payload got=%h want=0", sWord); end
        checks++; if (wordCnt !== 32'd0) begin failures++; $display("[TB] FAIL reset_word_cnt got=%0d want=0", wordCnt); end
        checks++; if (pktCnt !== 32'd0) begin failures++; $display("[TB] FAIL reset_pkt_cnt got=%0d want=0", pktCnt); end
    endtask

    task automatic test_streaming();
        logic [14:0] vBits;
        logic [14:0] rBits;
        int lastCnt;
        int mism;
        do_reset();
        for (int i = 0; i < 8; i++) push(mk(32'(i), i == 7));
        pkt.tready = 1'b1;
        rst = 1'b0;
        vBits = '0;
        rBits = '0;
        for (int k = 0; k < 15; k++) begin
            step();
            vBits[k] = sValid;
            rBits[k] = sRd;
        end
        checks++; if (vBits !== 15'h03FC) begin failures++; $display("[TB] FAIL stream_tvalid_cycles got=%h want=03fc", vBits); end
        checks++; if (rBits !== 15'h00FF) begin failures++; $display("[TB] FAIL stream_fifo_rd_cycles got=%h want=00ff", rBits); end
        lastCnt = 0;
        mism = 0;
        foreach (outWords[i]) begin
            if (outWords[i][3]) lastCnt++;
            if (i >= expWords.size() || outWords[i] !== expWords[i]) mism++;
        end
        checks++; if (outWords.size() != 8 || mism != 0) begin failures++; $display("[TB] FAIL stream_order got=%0d words/%0d bad want=8/0", outWords.size(), mism); end
        checks++; if (lastCnt != 1 || outWords.size() < 8 || outWords[7][3] !== 1'b1) begin failures++; $display("[TB] FAIL stream_tlast got=%0d want=1 on word 7", lastCnt); end
    endtask

    task automatic test_backpressure();
        int stallRd;
        int stallBad;
        int beats;
        logic rdAtRelease;
        int mism;
        do_reset();
        for (int i = 0; i < 6; i++) push(mk(32'(i), i == 5));
        pkt.tready = 1'b0;
        rst = 1'b0;
        stallRd = 0;
        stallBad = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (sRd) stallRd++;
            if (k >= 2 && (!sValid || sWord[43:12] !== 32'd0)) stallBad++;
        end
        pkt.tready = 1'b1;
        beats = 0;
        rdAtRelease = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (k == 0) rdAtRelease = sRd;
            if (sPop) beats++;
        end
        for (int k = 0; k < 3; k++) step();
        checks++; if (stallRd != 2) begin failures++; $display("[TB] FAIL bp_stall_reads got=%0d want=2", stallRd); end
        checks++; if (stallBad != 0) begin failures++; $display("[TB] FAIL bp_stall_payload got=%0d bad cycles want=0", stallBad); end
        checks++; if (beats != 6 || rdAtRelease !== 1'b1) begin failures++; $display("[TB] FAIL bp_no_bubble got=%0d beats rd=%b want=6 rd=1", beats, rdAtRelease); end
        mism = 0;
        foreach (outWords[i]) if (i >= expWords.size() || outWords[i] !== expWords[i]) mism++;
        checks++; if (outWords.size() != 6 || mism != 0) begin failures++; $display("[TB] FAIL bp_order got=%0d words/%0d bad want=6/0", outWords.size(), mism); end
    endtask

    task automatic test_random_ready();
        int pushed;
        int cyc;
        int mism;
        do_reset();
        rst = 1'b0;
        pushed = 0;
        cyc = 0;
        while (outWords.size() < 1000 && cyc < 8000) begin
            if (pushed < 1000 && $urandom_range(0, 3) != 0) begin
                push(mk(32'(pushed) ^ 32'hA5A5_0000, (pushed % 16) == 15));
                pushed++;
            end
            pkt.tready = 1'($urandom_range(0, 1));
            step();
            cyc++;
        end
        mism = 0;
        foreach (outWords[i]) if (i >= expWords.size() || outWords[i] !== expWords[i]) mism++;
        checks++; if (outWords.size() != 1000) begin failures++; $display("[TB] FAIL rand_word_count got=%0d want=1000", outWords.size()); end
        checks++; if (mism != 0) begin failures++; $display("[TB] FAIL rand_order got=%0d bad want=0", mism); end
        checks++; if (rdEmptyViol != 0) begin failures++; $display("[TB] FAIL rand_read_while_empty got=%0d want=0", rdEmptyViol); end
        checks++; if (overViol != 0) begin failures++; $display("[TB] FAIL rand_occupancy_over_2 got=%0d want=0", overViol); end
        checks++; if (holdViol != 0) begin failures++; $display("[TB] FAIL rand_hold_until_pop got=%0d want=0", holdViol); end
    endtask

    task automatic test_empty_mid_packet();
        logic [14:0] vBits;
        int lastCnt;
        int mism;
        do_reset();
        for (int i = 0; i < 3; i++) push(mk(32'(16 + i), 1'b0));
        pkt.tready = 1'b1;
        rst = 1'b0;
        vBits = '0;
        for (int k = 0; k < 15; k++) begin
            step();
            vBits[k] = sValid;
            if (k == 7) begin
                push(mk(32'd19, 1'b0));
                push(mk(32'd20, 1'b1));
            end
        end
        checks++; if (vBits !== 15'h0C1C) begin failures++; $display("[TB] FAIL gap_tvalid_cycles got=%h want=0c1c", vBits); end
        lastCnt = 0;
        mism = 0;
        foreach (outWords[i]) begin
            if (outWords[i][3]) lastCnt++;
            if (i >= expWords.size() || outWords[i] !== expWords[i]) mism++;
        end
        checks++; if (outWords.size() != 5 || mism != 0) begin failures++; $display("[TB] FAIL gap_beats got=%0d words/%0d bad want=5/0", outWords.size(), mism); end
        checks++; if (lastCnt != 1) begin failures++; $display("[TB] FAIL gap_tlast got=%0d want=1", lastCnt); end
    endtask

    task automatic test_reset_mid_stream();
        int staleBeats;
        int mism;
        do_reset();
        for (int i = 0; i < 5; i++) push(mk(32'(32 + i), 1'b0));
        pkt.tready = 1'b0;
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        expWords.delete();
        outWords.delete();
        step();
        checks++; if (sValid !== 1'b0 || sRd !== 1'b0) begin failures++; $display("[TB] FAIL midrst_outputs got=tvalid %b rd %b want=0 0", sValid, sRd); end
        checks++; if (wordCnt !== 32'd0 || pktCnt !== 32'd0) begin failures++; $display("[TB] FAIL midrst_counters got=%0d/%0d want=0/0", wordCnt, pktCnt); end
        pkt.tready = 1'b1;
        staleBeats = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (sValid) staleBeats++;
        end
        checks++; if (staleBeats != 0) begin failures++; $display("[TB] FAIL midrst_stale got=%0d valid cycles want=0", staleBeats); end
        push(mk(32'd40, 1'b0));
        push(mk(32'd41, 1'b1));
        for (int k = 0; k < 6; k++) step();
        mism = 0;
        foreach (outWords[i]) if (i >= expWords.size() || outWords[i] !== expWords[i]) mism++;
        checks++; if (outWords.size() != 2 || mism != 0) begin failures++; $display("[TB] FAIL midrst_resume got=%0d words/%0d bad want=2/0", outWords.size(), mism); end
    endtask

    task automatic test_stat();
        logic [31:0] expWordCnt;
        logic [31:0] expPktCnt;
`ifdef FIFO_TO_AXI4_STREAM_STAT_EN
        expWordCnt = 32'd12;
        expPktCnt  = 32'd3;
`else
        expWordCnt = 32'd0;
        expPktCnt  = 32'd0;
`endif
        do_reset();
        for (int i = 0; i < 12; i++) push(mk(32'(64 + i), (i % 4) == 3));
        pkt.tready = 1'b1;
        rst = 1'b0;
        for (int k = 0; k < 20; k++) step();
        checks++; if (wordCnt !== expWordCnt) begin failures++; $display("[TB] FAIL stat_word_cnt got=%0d want=%0d", wordCnt, expWordCnt); end
        checks++; if (pktCnt !== expPktCnt) begin failures++; $display("[TB] FAIL stat_pkt_cnt got=%0d want=%0d", pktCnt, expPktCnt); end
    endtask

    initial begin
        rst = 1'b1;
        fifoEmpty = 1'b1;
        fifoData = GARBAGE;
        pkt.tready = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_random_ready();
        test_empty_mid_packet();
        test_reset_mid_stream();
        test_stat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
